// File: rtl/oam_dma_controller.sv
`default_nettype none
// ============================================================================
// Module   : oam_dma_controller
// Brief    : Sprite DMA engine; halts the CPU and copies one source page to
//            the OAM data port, otherwise passes CPU bus traffic through.
// Revision : 1.0 - initial release
// ============================================================================
module oam_dma_controller #(
    parameter logic [15:0] TRIGGER_ADDRESS  = 16'h4014,
    parameter logic [15:0] OAM_DATA_ADDRESS = 16'h2004,
    parameter int          TRANSFER_LENGTH  = 256
) (
    input  logic        clock_i,
    input  logic        reset_i,
    input  logic        cpu_tick_i,
    input  logic [15:0] cpu_address_i,
    input  logic [7:0]  cpu_data_i,
    input  logic        cpu_bus_read_i,
    input  logic        cpu_bus_write_i,
    output logic        cpu_halt_o,
    input  logic [7:0]  bus_data_i,
    output logic [15:0] bus_address_o,
    output logic [7:0]  bus_data_o,
    output logic        bus_read_o,
    output logic        bus_write_o,
    output logic        busy_o
);

    localparam logic [7:0] c_last_index = 8'(TRANSFER_LENGTH - 1);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_HALT  = 3'd1,
        S_ALIGN = 3'd2,
        S_READ  = 3'd3,
        S_WRITE = 3'd4
    } state_t;

    state_t      r_state, w_state_next;
    logic        r_parity;
    logic [7:0]  r_page, w_page_next;
    logic [7:0]  r_index, w_index_next;
    logic [7:0]  r_hold, w_hold_next;
    logic [15:0] r_dma_address, w_dma_address_next;
    logic        r_dma_read, w_dma_read_next;
    logic        r_dma_write, w_dma_write_next;
    logic        r_busy, w_busy_next;
    logic        w_trigger;

    assign w_trigger = cpu_bus_write_i && (cpu_address_i == TRIGGER_ADDRESS);

    always_ff @(posedge clock_i or posedge reset_i) begin
        if (reset_i) begin
            r_state       <= S_IDLE;
            r_parity      <= 1'b0;
            r_page        <= 8'h00;
            r_index       <= 8'h00;
            r_hold        <= 8'h00;
            r_dma_address <= 16'h0000;
            r_dma_read    <= 1'b0;
            r_dma_write   <= 1'b0;
            r_busy        <= 1'b0;
        end else if (cpu_tick_i) begin
            r_state       <= w_state_next;
            r_parity      <= ~r_parity;
            r_page        <= w_page_next;
            r_index       <= w_index_next;
            r_hold        <= w_hold_next;
            r_dma_address <= w_dma_address_next;
            r_dma_read    <= w_dma_read_next;
            r_dma_write   <= w_dma_write_next;
            r_busy        <= w_busy_next;
        end
    end

    // Bus registers are loaded on the edge entering each state, so a READ
    // address is valid for the whole READ tick.
    always_comb begin
        w_state_next       = r_state;
        w_page_next        = r_page;
        w_index_next       = r_index;
        w_hold_next        = r_hold;
        w_dma_address_next = r_dma_address;
        w_dma_read_next    = 1'b0;
        w_dma_write_next   = 1'b0;
        w_busy_next        = r_busy;
        case (r_state)
            S_IDLE: begin
                if (w_trigger) begin
                    w_page_next  = cpu_data_i;
                    w_index_next = 8'h00;
                    w_busy_next  = 1'b1;
                    w_state_next = S_HALT;
                end
            end
            S_HALT: begin
                if (r_parity) begin
                    w_state_next = S_ALIGN;
                end else begin
                    w_state_next       = S_READ;
                    w_dma_address_next = {r_page, r_index};
                    w_dma_read_next    = 1'b1;
                end
            end
            S_ALIGN: begin
                w_state_next       = S_READ;
                w_dma_address_next = {r_page, r_index};
                w_dma_read_next    = 1'b1;
            end
            S_READ: begin
                w_state_next       = S_WRITE;
                w_hold_next        = bus_data_i;
                w_dma_address_next = OAM_DATA_ADDRESS;
                w_dma_write_next   = 1'b1;
            end
            S_WRITE: begin
                if (r_index == c_last_index) begin
                    w_state_next = S_IDLE;
                    w_busy_next  = 1'b0;
                end else begin
                    w_index_next       = r_index + 8'd1;
                    w_state_next       = S_READ;
                    w_dma_address_next = {r_page, r_index + 8'd1};
                    w_dma_read_next    = 1'b1;
                end
            end
            default: begin
                w_state_next = S_IDLE;
                w_busy_next  = 1'b0;
            end
        endcase
    end

    assign bus_address_o = (r_state == S_IDLE) ? cpu_address_i   : r_dma_address;
    assign bus_data_o    = (r_state == S_IDLE) ? cpu_data_i      : r_hold;
    assign bus_read_o    = (r_state == S_IDLE) ? cpu_bus_read_i  : r_dma_read;
    assign bus_write_o   = (r_state == S_IDLE) ? cpu_bus_write_i : r_dma_write;
    assign cpu_halt_o    = r_busy;
    assign busy_o        = r_busy;

endmodule
`default_nettype wire

// File: tb/tb_oam_dma_controller.sv
`default_nettype none
// ============================================================================
// Module   : tb_oam_dma_controller
// Brief    : Self-checking bench: passthrough vector table plus scoreboarded
//            DMA transfers covering parity alignment, page wrap, reset, gating.
// Revision : 1.0 - initial release
// ============================================================================
module tb_oam_dma_controller;

    logic        clock_i = 1'b0;
    logic        reset_i;
    logic        cpu_tick_i;
    logic [15:0] cpu_address_i;
    logic [7:0]  cpu_data_i;
    logic        cpu_bus_read_i;
    logic        cpu_bus_write_i;
    logic        cpu_halt_o;
    logic [7:0]  bus_data_i;
    logic [15:0] bus_address_o;
    logic [7:0]  bus_data_o;
    logic        bus_read_o;
    logic        bus_write_o;
    logic        busy_o;

    oam_dma_controller dut (
        .clock_i         (clock_i),
        .reset_i         (reset_i),
        .cpu_tick_i      (cpu_tick_i),
        .cpu_address_i   (cpu_address_i),
        .cpu_data_i      (cpu_data_i),
        .cpu_bus_read_i  (cpu_bus_read_i),
        .cpu_bus_write_i (cpu_bus_write_i),
        .cpu_halt_o      (cpu_halt_o),
        .bus_data_i      (bus_data_i),
        .bus_address_o   (bus_address_o),
        .bus_data_o      (bus_data_o),
        .bus_read_o      (bus_read_o),
        .bus_write_o     (bus_write_o),
        .busy_o          (busy_o)
    );

    always #5 clock_i = ~clock_i;

    // Memory image: every location holds its low address byte xor 0x5A.
    assign bus_data_i = bus_address_o[7:0] ^ 8'h5A;

    int vectors     = 0;
    int miscompares = 0;
    int wr_count    = 0;
    int halt_cnt    = 0;
    logic        tb_par;
    logic [15:0] rdq[$];
    logic [7:0]  wrq[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Parity of the tick about to occur (tick count since reset, mod 2).
    always @(posedge clock_i or posedge reset_i) begin
        if (reset_i)         tb_par <= 1'b0;
        else if (cpu_tick_i) tb_par <= ~tb_par;
    end

    // Scoreboard monitor: compare DMA accesses against queue heads; pop on ticks.
    always @(negedge clock_i) begin
        if (!reset_i && busy_o) begin
            if (bus_read_o) begin
                if (rdq.size() == 0) begin
                    check("unexpected_read", {16'h0, bus_address_o}, 32'hFFFF_FFFF);
                end else begin
                    check("read_addr", {16'h0, bus_address_o}, {16'h0, rdq[0]});
                    if (cpu_tick_i) void'(rdq.pop_front());
                end
            end
            if (bus_write_o) begin
                if (wrq.size() == 0) begin
                    check("unexpected_write", {16'h0, bus_address_o}, 32'hFFFF_FFFF);
                end else begin
                    check("write_addr", {16'h0, bus_address_o}, 32'h2004);
                    check("write_data", {24'h0, bus_data_o}, {24'h0, wrq[0]});
                    if (cpu_tick_i) begin
                        void'(wrq.pop_front());
                        wr_count++;
                    end
                end
            end
            if (cpu_tick_i && cpu_halt_o) halt_cnt++;
        end
    end

    task automatic step();
        @(posedge clock_i);
        #1;
    endtask

    task automatic start_transfer(input logic [7:0] page, input logic want_par);
        int guard = 0;
        while (tb_par !== want_par && guard < 4) begin
            step();
            guard++;
        end
        for (int i = 0; i < 256; i++) begin
            rdq.push_back({page, 8'(i)});
            wrq.push_back(8'(i) ^ 8'h5A);
        end
        halt_cnt        = 0;
        wr_count        = 0;
        cpu_address_i   = 16'h4014;
        cpu_data_i      = page;
        cpu_bus_write_i = 1'b1;
        step();
        cpu_address_i   = 16'h0000;
        cpu_data_i      = 8'h00;
        cpu_bus_write_i = 1'b0;
        check("halt_after_trigger", {31'h0, cpu_halt_o}, 32'h1);
        check("busy_after_trigger", {31'h0, busy_o}, 32'h1);
    endtask

    task automatic finish_transfer(input logic [7:0] page, input bit do_gate, input int exp_halt);
        int  cycles = 0;
        bit  gated  = 0;
        while (busy_o && cycles < 3000) begin
            step();
            cycles++;
            if (do_gate && !gated && wr_count == 50 && bus_read_o) begin
                cpu_tick_i = 1'b0;
                for (int g = 0; g < 20; g++) begin
                    @(negedge clock_i);
                    check("gate_read", {31'h0, bus_read_o}, 32'h1);
                    check("gate_addr", {16'h0, bus_address_o}, {16'h0, page, 8'd50});
                    check("gate_halt", {31'h0, cpu_halt_o}, 32'h1);
                end
                step();
                cpu_tick_i = 1'b1;
                gated      = 1;
            end
        end
        check("transfer_timeout", {31'h0, busy_o}, 32'h0);
        check("halt_ticks", halt_cnt, exp_halt);
        check("write_count", wr_count, 256);
        check("rdq_left", rdq.size(), 0);
        check("wrq_left", wrq.size(), 0);
        check("halt_released", {31'h0, cpu_halt_o}, 32'h0);
    endtask

    typedef struct {
        logic [15:0] addr;
        logic [7:0]  data;
        logic        rd;
        logic        wr;
        logic [15:0] exp_addr;
        logic [7:0]  exp_data;
        logic        exp_rd;
        logic        exp_wr;
        logic        exp_busy;
    } pt_vec_t;

    pt_vec_t pt_tab[5];

    initial begin
        pt_tab[0] = '{16'h0123, 8'h00, 1'b1, 1'b0, 16'h0123, 8'h00, 1'b1, 1'b0, 1'b0};
        pt_tab[1] = '{16'h4015, 8'hAA, 1'b0, 1'b1, 16'h4015, 8'hAA, 1'b0, 1'b1, 1'b0};
        pt_tab[2] = '{16'h4014, 8'h33, 1'b1, 1'b0, 16'h4014, 8'h33, 1'b1, 1'b0, 1'b0};
        pt_tab[3] = '{16'h2004, 8'hC3, 1'b0, 1'b1, 16'h2004, 8'hC3, 1'b0, 1'b1, 1'b0};
        pt_tab[4] = '{16'hFFFF, 8'h7E, 1'b1, 1'b0, 16'hFFFF, 8'h7E, 1'b1, 1'b0, 1'b0};

        reset_i         = 1'b1;
        cpu_tick_i      = 1'b1;
        cpu_address_i   = 16'h0000;
        cpu_data_i      = 8'h00;
        cpu_bus_read_i  = 1'b0;
        cpu_bus_write_i = 1'b0;
        repeat (3) step();
        check("reset_halt", {31'h0, cpu_halt_o}, 32'h0);
        check("reset_busy", {31'h0, busy_o}, 32'h0);
        check("reset_read", {31'h0, bus_read_o}, 32'h0);
        check("reset_write", {31'h0, bus_write_o}, 32'h0);
        reset_i = 1'b0;
        step();

        foreach (pt_tab[k]) begin
            cpu_address_i   = pt_tab[k].addr;
            cpu_data_i      = pt_tab[k].data;
            cpu_bus_read_i  = pt_tab[k].rd;
            cpu_bus_write_i = pt_tab[k].wr;
            @(negedge clock_i);
            check("pt_addr", {16'h0, bus_address_o}, {16'h0, pt_tab[k].exp_addr});
            check("pt_data", {24'h0, bus_data_o}, {24'h0, pt_tab[k].exp_data});
            check("pt_read", {31'h0, bus_read_o}, {31'h0, pt_tab[k].exp_rd});
            check("pt_write", {31'h0, bus_write_o}, {31'h0, pt_tab[k].exp_wr});
            check("pt_halt", {31'h0, cpu_halt_o}, 32'h0);
            step();
            check("pt_busy", {31'h0, busy_o}, {31'h0, pt_tab[k].exp_busy});
        end
        cpu_address_i   = 16'h0000;
        cpu_data_i      = 8'h00;
        cpu_bus_read_i  = 1'b0;
        cpu_bus_write_i = 1'b0;
        step();

        // Trigger tick parity 1 -> HALT tick parity 0 -> no align.
        start_transfer(8'h02, 1'b1);
        finish_transfer(8'h02, 1'b0, 513);

        // Trigger tick parity 0 -> one ALIGN tick, with a 20-clock tick stall.
        start_transfer(8'h02, 1'b0);
        finish_transfer(8'h02, 1'b1, 514);

        start_transfer(8'hFF, 1'b1);
        finish_transfer(8'hFF, 1'b0, 513);

        // Asynchronous reset after the 100th DMA write.
        start_transfer(8'h02, 1'b1);
        begin
            int cycles = 0;
            while (wr_count < 100 && cycles < 1000) begin
                step();
                cycles++;
            end
        end
        check("reach_100_writes", wr_count, 100);
        #2 reset_i = 1'b1;
        #1;
        check("arst_halt", {31'h0, cpu_halt_o}, 32'h0);
        check("arst_busy", {31'h0, busy_o}, 32'h0);
        check("arst_write", {31'h0, bus_write_o}, 32'h0);
        check("arst_read", {31'h0, bus_read_o}, 32'h0);
        rdq.delete();
        wrq.delete();
        step();
        step();
        reset_i = 1'b0;
        step();
        check("post_reset_idle_write", {31'h0, bus_write_o}, 32'h0);
        start_transfer(8'h03, 1'b0);
        finish_transfer(8'h03, 1'b0, 514);

        repeat (3) step();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
`default_nettype wire
